seseg_scan: RTL and testbench
=============================

SESEG_SCAN -- requirements
Module: seseg_scan

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 Parameter CLK_DIV, default 50000, clk cycles per digit slot; legal minimum 2.
REQ-003 Parameter DEAD_CYCLES, default 16, anode-off cycles at the start of each slot; legal range 0..CLK_DIV-1.
REQ-004 Parameter BLINK_SCANS, default 64, full scans per blink phase; legal minimum 1.
REQ-005 Clocking SHALL be one clock; reset SHALL be asynchronous and active-low: clk  in  1  clock; rst_n  in  1  async active-low reset.
REQ-006 value  in  4*NUM_DIGITS  hex nibbles, digit 0 in bits [3:0].
REQ-007 load  in  1  capture value/dp/blank_mask/blink_mask into shadow registers.
REQ-008 dp  in  NUM_DIGITS  decimal point request per digit, active-high.
REQ-009 blank_mask  in  NUM_DIGITS  force digit dark, active-high.
REQ-010 blink_mask  in  NUM_DIGITS  digit blinks, active-high.
REQ-011 lz_en  in  1  leading-zero suppression enable, live (not shadowed).
REQ-012 seg  out  7  segments, active-low, bit0=a ... bit6=g.
REQ-013 dp_n  out  1  decimal point, active-low.
REQ-014 an  out  NUM_DIGITS  digit enables, active-low, one-hot-low or all-high.

Function
REQ-015 Segment encoding SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1011000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110 (written g..a).
REQ-016 Prescaler SHALL count 0..CLK_DIV-1 and wrap to 0; a wrap SHALL advance digit index idx by 1, wrapping NUM_DIGITS-1 -> 0.
REQ-017 A wrap with idx=NUM_DIGITS-1 SHALL count one completed scan; after BLINK_SCANS completed scans the blink phase SHALL toggle and the scan counter SHALL clear.
REQ-018 Shadow registers SHALL capture on any clk edge with load=1; slot timing SHALL NOT be disturbed by load.
REQ-019 Load and prescaler wrap in the same cycle: the new idx SHALL display the newly loaded shadow data.
REQ-020 All outputs SHALL be registered; outputs in cycle t+1 reflect prescaler, idx, phase, shadow and lz_en in cycle t.
REQ-021 an[idx] SHALL be low only when prescaler >= DEAD_CYCLES and the digit is not dark; all other an bits SHALL be high.
REQ-022 A digit SHALL be dark when blank_mask bit set, or blink_mask bit set and blink phase=1, or suppressed by REQ-023.
REQ-023 With lz_en=1, digit k>0 SHALL be suppressed when its nibble and every higher nibble are 0; digit 0 SHALL never be suppressed.
REQ-024 Dark digit or dead time: seg SHALL be 1111111 and dp_n SHALL be 1.
REQ-025 Lit digit: seg SHALL be the REQ-015 code of its nibble; dp_n SHALL be ~dp shadow bit.

Reset
REQ-026 While rst_n=0: prescaler=0, idx=0, scan counter=0, blink phase=0, all shadow registers=0, seg=1111111, dp_n=1, an all high.
REQ-027 Reset assertion mid-slot SHALL force REQ-026 values immediately; after release, the first slot SHALL be digit 0 with full dead time.

Structure
REQ-028 Segment code constants (16 codes and SEG_OFF=1111111) SHALL live in a shared package seseg_pkg.
REQ-029 Nibble-to-segment mapping SHALL be a combinational sub-module hex7_dec; seseg_scan holds all sequential logic.
REQ-030 Illegal parameter values SHALL be rejected at elaboration.

Verification
REQ-031 NUM_DIGITS=4, CLK_DIV=8, DEAD_CYCLES=2, load value=0x1234 -> an sequence 1110,1101,1011,0111 per 8-cycle slot, segs 2=... digit0 seg=0110000 (3? no: nibble 4) i.e. digit0=0011001, digit3=1111001; an high for first 2 cycles of each slot.
REQ-032 Load 0x00A0, lz_en=1 -> digits 3,2 dark (an bits high, seg 1111111), digit1 seg=0001000, digit0 seg=1000000; lz_en=0 -> digits 3,2 show 1000000.
REQ-033 blink_mask=0001, BLINK_SCANS=2 -> digit 0 lit for 2 scans, dark for 2 scans, repeating; other digits unaffected.
REQ-034 load=1 in the wrap cycle 3->0 with value 0xFFFF -> digit 0 slot shows 0001110, never the old nibble.
REQ-035 rst_n pulsed low mid-slot of digit 2 -> outputs at REQ-026 values the same cycle; after release, first lit output is digit 0 at cycle DEAD_CYCLES+1.
REQ-036 dp=0100, value=0x8888 -> dp_n=0 only during digit 2 lit cycles; seg=0000000 for all lit digits.

Source files
------------

// File: rtl/seseg_pkg.sv
// Shared constants for the seven-segment scanner.
// Segment codes are active-low, bit0=a ... bit6=g.
package seseg_pkg;

   localparam logic [6:0] SEG_OFF = 7'b1111111;

   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_6 = 7'b0000010;
   localparam logic [6:0] SEG_7 = 7'b1011000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0010000;
   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_B = 7'b0000011;
   localparam logic [6:0] SEG_C = 7'b1000110;
   localparam logic [6:0] SEG_D = 7'b0100001;
   localparam logic [6:0] SEG_E = 7'b0000110;
   localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/hex7_dec.sv
// Combinational hex nibble to active-low segment decoder.
module hex7_dec
   import seseg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_OFF;
      case (nibble)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         4'hF: seg = SEG_F;
         default: seg = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/seseg_scan.sv
// Multiplexed seven-segment scanner with dead time, blanking,
// blinking and leading-zero suppression; all outputs registered.
module seseg_scan
   import seseg_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int CLK_DIV     = 50000,
   parameter int DEAD_CYCLES = 16,
   parameter int BLINK_SCANS = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic                    load,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic [NUM_DIGITS-1:0]   blank_mask,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   input  logic                    lz_en,
   output logic [6:0]              seg,
   output logic                    dp_n,
   output logic [NUM_DIGITS-1:0]   an
);

   localparam int PW = $clog2(CLK_DIV);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int SW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

   localparam logic [PW-1:0] P_LAST = PW'(CLK_DIV - 1);
   localparam logic [PW-1:0] P_DEAD = PW'(DEAD_CYCLES);
   localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);
   localparam logic [SW-1:0] S_LAST = SW'(BLINK_SCANS - 1);

   generate
      if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
         $error("seseg_scan: NUM_DIGITS must be 1..8");
      end
      if (CLK_DIV < 2) begin : g_bad_div
         $error("seseg_scan: CLK_DIV must be >= 2");
      end
      if (DEAD_CYCLES < 0 || DEAD_CYCLES > CLK_DIV - 1) begin : g_bad_dead
         $error("seseg_scan: DEAD_CYCLES must be 0..CLK_DIV-1");
      end
      if (BLINK_SCANS < 1) begin : g_bad_blink
         $error("seseg_scan: BLINK_SCANS must be >= 1");
      end
   endgenerate

   logic [PW-1:0]           presc;
   logic [IW-1:0]           idx;
   logic [SW-1:0]           scans;
   logic                    phase;
   logic [4*NUM_DIGITS-1:0] sh_value;
   logic [NUM_DIGITS-1:0]   sh_dp;
   logic [NUM_DIGITS-1:0]   sh_blank;
   logic [NUM_DIGITS-1:0]   sh_blink;

   logic                    wrap;
   logic [NUM_DIGITS-1:0]   supp;
   logic                    hi_zero;
   logic [3:0]              nib;
   logic [6:0]              code;
   logic                    dark;
   logic                    lit;
   logic [NUM_DIGITS-1:0]   onehot;
   logic [6:0]              seg_nxt;
   logic                    dp_n_nxt;

   assign wrap = (presc == P_LAST);
   assign nib  = sh_value[{idx, 2'b00} +: 4];

   hex7_dec u_dec (
      .nibble (nib),
      .seg    (code)
   );

   // Digit k is blank when it and everything above it is zero.
   always_comb begin
      supp    = '0;
      hi_zero = 1'b1;
      for (int k = NUM_DIGITS - 1; k > 0; k--) begin
         hi_zero = hi_zero && (sh_value[4*k +: 4] == 4'h0);
         supp[k] = lz_en && hi_zero;
      end
   end

   always_comb begin
      dark        = sh_blank[idx] | (sh_blink[idx] & phase) | supp[idx];
      lit         = (presc >= P_DEAD) && !dark;
      onehot      = '0;
      onehot[idx] = lit;
      seg_nxt     = lit ? code : SEG_OFF;
      dp_n_nxt    = lit ? ~sh_dp[idx] : 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc    <= '0;
         idx      <= '0;
         scans    <= '0;
         phase    <= 1'b0;
         sh_value <= '0;
         sh_dp    <= '0;
         sh_blank <= '0;
         sh_blink <= '0;
         seg      <= SEG_OFF;
         dp_n     <= 1'b1;
         an       <= '1;
      end else begin
         presc <= wrap ? '0 : presc + 1'b1;
         if (wrap) begin
            idx <= (idx == I_LAST) ? '0 : idx + 1'b1;
            if (idx == I_LAST) begin
               if (scans == S_LAST) begin
                  scans <= '0;
                  phase <= ~phase;
               end else begin
                  scans <= scans + 1'b1;
               end
            end
         end
         if (load) begin
            sh_value <= value;
            sh_dp    <= dp;
            sh_blank <= blank_mask;
            sh_blink <= blink_mask;
         end
         seg  <= seg_nxt;
         dp_n <= dp_n_nxt;
         an   <= ~onehot;
      end
   end

endmodule

// File: tb/tb_seseg_scan.sv
// Scoreboard bench for seseg_scan: a slot-arithmetic reference model
// pushes expected outputs, a monitor pops and compares them.
module tb_seseg_scan;

   localparam int ND   = 4;
   localparam int CDIV = 8;
   localparam int DEAD = 2;
   localparam int BS   = 2;
   localparam logic [11:0] OFF_W = {7'b1111111, 4'b1111, 1'b1};

   logic        clk;
   logic        rst_n;
   logic [15:0] value;
   logic        load;
   logic [3:0]  dp;
   logic [3:0]  blank_mask;
   logic [3:0]  blink_mask;
   logic        lz_en;
   logic [6:0]  seg;
   logic        dp_n;
   logic [3:0]  an;

   seseg_scan #(
      .NUM_DIGITS  (ND),
      .CLK_DIV     (CDIV),
      .DEAD_CYCLES (DEAD),
      .BLINK_SCANS (BS)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .value      (value),
      .load       (load),
      .dp         (dp),
      .blank_mask (blank_mask),
      .blink_mask (blink_mask),
      .lz_en      (lz_en),
      .seg        (seg),
      .dp_n       (dp_n),
      .an         (an)
   );

   int          checks   = 0;
   int          failures = 0;
   int          ticks    = 0;
   logic [11:0] sb_q[$];

   logic [15:0] m_val;
   logic [3:0]  m_dp;
   logic [3:0]  m_blank;
   logic [3:0]  m_blink;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [6:0] seg_code(input logic [3:0] n);
      case (n)
         4'h0: return 7'b1000000;
         4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;
         4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;
         4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;
         4'h7: return 7'b1011000;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;
         4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;
         4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;
         default: return 7'b0001110;
      endcase
   endfunction

   // Expected output after the edge ending cycle t (t cycles since reset).
   function automatic logic [11:0] ref_out(
      input int t, input logic [15:0] v, input logic [3:0] dpv,
      input logic [3:0] bl, input logic [3:0] bk, input logic lz);
      int          pre;
      int          slot;
      int          d;
      int          ph;
      logic [3:0]  nib;
      logic [3:0]  a;
      logic        dark;
      pre  = t % CDIV;
      slot = t / CDIV;
      d    = slot % ND;
      ph   = (slot / (ND * BS)) % 2;
      nib  = 4'((v >> (4 * d)) & 16'hF);
      dark = bl[d] || (bk[d] && ph == 1) ||
             (lz && d > 0 && (v >> (4 * d)) == 16'h0);
      if (pre < DEAD || dark) return OFF_W;
      a = ~(4'b0001 << d);
      return {seg_code(nib), a, ~dpv[d]};
   endfunction

   // Reference model
   initial forever begin
      @(posedge clk);
      if (!rst_n) begin
         ticks   = 0;
         m_val   = '0;
         m_dp    = '0;
         m_blank = '0;
         m_blink = '0;
         sb_q.push_back(OFF_W);
      end else begin
         sb_q.push_back(ref_out(ticks, m_val, m_dp, m_blank, m_blink, lz_en));
         if (load) begin
            m_val   = value;
            m_dp    = dp;
            m_blank = blank_mask;
            m_blink = blink_mask;
         end
         ticks++;
      end
   end

   // Monitor
   initial forever begin
      logic [11:0] got;
      logic [11:0] exp;
      @(negedge clk or negedge rst_n);
      if (clk === 1'b1) begin
         #1;
         got = {seg, an, dp_n};
         checks++;
         if (got !== OFF_W) begin
            failures++;
            $display("FAIL rst_async t=%0t got seg=%b an=%b dp_n=%b exp seg=%b an=%b dp_n=%b",
                     $time, got[11:5], got[4:1], got[0],
                     OFF_W[11:5], OFF_W[4:1], OFF_W[0]);
         end
      end else if (sb_q.size() > 0) begin
         exp = sb_q.pop_front();
         if (!rst_n) exp = OFF_W;
         got = {seg, an, dp_n};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL out t=%0t got seg=%b an=%b dp_n=%b exp seg=%b an=%b dp_n=%b",
                     $time, got[11:5], got[4:1], got[0],
                     exp[11:5], exp[4:1], exp[0]);
         end
      end
   end

   task automatic do_load(input logic [15:0] v, input logic [3:0] d,
                          input logic [3:0] bl, input logic [3:0] bk);
      @(negedge clk);
      value      = v;
      dp         = d;
      blank_mask = bl;
      blink_mask = bk;
      load       = 1'b1;
      @(negedge clk);
      load       = 1'b0;
   endtask

   task automatic wait_tick(input int phase_mod, input string name);
      bit hit;
      hit = 0;
      for (int i = 0; i < 4 * ND * CDIV && !hit; i++) begin
         @(negedge clk);
         if (ticks % (ND * CDIV) == phase_mod) hit = 1;
      end
      if (!hit) begin
         $display("FAIL wait_%s slot position %0d not reached", name, phase_mod);
         $fatal(1, "wait bound expired");
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      value      = '0;
      load       = 1'b0;
      dp         = '0;
      blank_mask = '0;
      blink_mask = '0;
      lz_en      = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;

      do_load(16'h1234, 4'b0000, 4'b0000, 4'b0000);
      repeat (80) @(negedge clk);

      lz_en = 1'b1;
      do_load(16'h00A0, 4'b0000, 4'b0000, 4'b0000);
      repeat (70) @(negedge clk);
      lz_en = 1'b0;
      repeat (70) @(negedge clk);

      do_load(16'h5678, 4'b0000, 4'b0000, 4'b0001);
      repeat (160) @(negedge clk);

      // load coinciding with the 3 -> 0 wrap
      do_load(16'h1234, 4'b0000, 4'b0000, 4'b0000);
      wait_tick(ND * CDIV - 1, "wrap");
      value = 16'hFFFF;
      load  = 1'b1;
      @(negedge clk);
      load  = 1'b0;
      repeat (40) @(negedge clk);

      do_load(16'h8888, 4'b0100, 4'b0000, 4'b0000);
      repeat (40) @(negedge clk);

      // async reset in the middle of digit 2's slot
      wait_tick(2 * CDIV + 4, "digit2");
      @(posedge clk);
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (50) @(negedge clk);

      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         value      = ($urandom_range(0, 3) == 0) ?
                      16'($urandom_range(0, 255)) : 16'($urandom);
         dp         = 4'($urandom);
         blank_mask = 4'($urandom & $urandom & $urandom);
         blink_mask = 4'($urandom & $urandom);
         load       = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 63) == 0) lz_en = ~lz_en;
      end
      @(negedge clk);
      load = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
